// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline: EX captures operands (with bypass from the
// in-flight result), WB holds the retired result for the downstream consumer.

module alu #(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic            v;
    logic            c;

    always_comb begin
        sum    = '0;
        v      = 1'b0;
        c      = 1'b0;
        result = '0;
        case (func)
            3'b000: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[MSB:0];
                c      = sum[DATA_W];
                v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            3'b001: begin
                // C set means no borrow
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result = sum[MSB:0];
                c      = sum[DATA_W];
                v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            3'b010, 3'b011: result = a & b;
            3'b100:         result = a | b;
            3'b101:         result = a ^ b;
            default:        result = ~a;
        endcase
        // P marks a strictly positive signed result
        flags = {v, c, ~result[MSB] & (|result), ~(|result)};
    end
endmodule

module alu_exec_stage #(
    parameter  int DATA_W     = 8,
    parameter  int REG_COUNT  = 8,
    localparam int REG_ADDR_W = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_alu_func,
    input  logic [REG_ADDR_W-1:0] in_src_a,
    input  logic [REG_ADDR_W-1:0] in_src_b,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_reg_we,
    input  logic                  in_flag_we,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [3:0]            out_flags,
    output logic [3:0]            flags_q
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and the payload is held while
    // valid is high and ready is low.

    logic                  ex_valid;
    logic [2:0]            ex_func;
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_we;
    logic                  ex_flag_we;
    logic                  wb_valid;
    logic [DATA_W-1:0]     regs [REG_COUNT];

    logic [DATA_W-1:0]     alu_result;
    logic [3:0]            alu_flags;
    logic                  ex_adv;
    logic                  accept;
    logic                  bypass_a;
    logic                  bypass_b;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;

    alu #(.DATA_W(DATA_W)) u_alu (
        .func   (ex_func),
        .a      (ex_a),
        .b      (ex_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign ex_adv    = ex_valid & (~wb_valid | out_ready);
    assign in_ready  = ~flush & (~ex_valid | ex_adv);
    assign accept    = in_valid & in_ready;
    assign out_valid = wb_valid;

    // An operand produced by the op now in EX is taken from the ALU directly,
    // since the register file write lands on the same edge as this capture.
    assign bypass_a = ex_valid & ex_reg_we & (ex_dest == in_src_a);
    assign bypass_b = ex_valid & ex_reg_we & (ex_dest == in_src_b);
    assign op_a     = bypass_a ? alu_result : regs[in_src_a];
    assign op_b     = in_use_imm ? in_imm : (bypass_b ? alu_result : regs[in_src_b]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_func    <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_dest    <= '0;
            ex_reg_we  <= 1'b0;
            ex_flag_we <= 1'b0;
            wb_valid   <= 1'b0;
            out_result <= '0;
            out_dest   <= '0;
            out_flags  <= '0;
            flags_q    <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (flush) begin
            ex_valid <= 1'b0;
            wb_valid <= 1'b0;
        end else begin
            if (ex_adv) begin
                wb_valid   <= 1'b1;
                out_result <= alu_result;
                out_dest   <= ex_dest;
                out_flags  <= alu_flags;
                if (ex_reg_we) begin
                    regs[ex_dest] <= alu_result;
                end
                if (ex_flag_we) begin
                    flags_q <= alu_flags;
                end
            end else if (out_ready) begin
                wb_valid <= 1'b0;
            end

            if (accept) begin
                ex_valid   <= 1'b1;
                ex_func    <= in_alu_func;
                ex_a       <= op_a;
                ex_b       <= op_b;
                ex_dest    <= in_dest;
                ex_reg_we  <= in_reg_we;
                ex_flag_we <= in_flag_we;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios plus randomized traffic, checked
// against a sequential architectural model of the register file and flags.

module tb_alu_exec_stage;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_alu_func = '0;
    logic [AW-1:0] in_src_a = '0;
    logic [AW-1:0] in_src_b = '0;
    logic [DW-1:0] in_imm = '0;
    logic          in_use_imm = 1'b0;
    logic [AW-1:0] in_dest = '0;
    logic          in_reg_we = 1'b0;
    logic          in_flag_we = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [AW-1:0] out_dest;
    logic [3:0]    out_flags;
    logic [3:0]    flags_q;

    logic          rdy_rand = 1'b0;
    logic          rdy_fixed = 1'b1;
    logic          rdy_bit = 1'b1;
    assign out_ready = rdy_rand ? rdy_bit : rdy_fixed;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] m_regs [8];
    logic [3:0]    m_flags;
    logic [14:0]   exp_q [$];

    alu_exec_stage #(.DATA_W(DW), .REG_COUNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_func(in_alu_func), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_dest(in_dest),
        .in_reg_we(in_reg_we), .in_flag_we(in_flag_we), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_flags(out_flags), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rdy_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic; returns {result, V, C, P, Z}.
    function automatic logic [11:0] ref_alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        logic v = 1'b0;
        logic c = 1'b0;
        logic [7:0] res;
        case (f)
            3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2, 3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            default: r = 255 - ua;
        endcase
        res = r[7:0];
        return {res, v, c, ($signed(res) > 0), (res == 8'd0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = '0;
        exp_q.delete();
    endtask

    // Ops execute in program order, so applying each at accept time is exact.
    task automatic model_exec();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] r;
        a = m_regs[in_src_a];
        b = in_use_imm ? in_imm : m_regs[in_src_b];
        r = ref_alu(in_alu_func, a, b);
        if (in_reg_we) m_regs[in_dest] = r[11:4];
        if (in_flag_we) m_flags = r[3:0];
        exp_q.push_back({r[11:4], in_dest, r[3:0]});
    endtask

    task automatic set_op(input logic [2:0] f, input logic [2:0] sa, input logic [2:0] sb,
                          input logic [7:0] imm, input logic ui, input logic [2:0] d,
                          input logic rwe, input logic fwe);
        in_valid = 1'b1; in_alu_func = f; in_src_a = sa; in_src_b = sb;
        in_imm = imm; in_use_imm = ui; in_dest = d; in_reg_we = rwe; in_flag_we = fwe;
    endtask

    task automatic issue(input logic [2:0] f, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [7:0] imm, input logic ui, input logic [2:0] d,
                         input logic rwe, input logic fwe);
        set_op(f, sa, sb, imm, ui, d, rwe, fwe);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                model_exec();
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("issue_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_q_empty", exp_q.size(), 0);
        check("arch_flags", flags_q, m_flags);
        @(posedge clk); #1;
    endtask

    task automatic read_all_regs();
        for (int r = 0; r < 8; r++) issue(3'd0, r[2:0], 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
        wait_drain();
    endtask

    // Scoreboard: every downstream transfer must match the oldest expected op.
    always @(negedge clk) begin
        logic [14:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_spurious", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_result", out_result, e[14:7]);
                check("out_dest", out_dest, e[6:4]);
                check("out_flags", out_flags, e[3:0]);
            end
        end
    end

    initial begin
        logic [7:0]  saved_regs [8];
        logic [3:0]  saved_flags;
        logic [14:0] held;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags_q", flags_q, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_dest", out_dest, 0);
        check("rst_out_flags", out_flags, 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back dependency through the bypass
        issue(3'd0, 3'd0, 3'd0, 8'h7F, 1'b1, 3'd1, 1'b1, 1'b1);
        issue(3'd0, 3'd1, 3'd0, 8'h01, 1'b1, 3'd2, 1'b1, 1'b1);
        wait_drain();
        check("bypass_flags", flags_q, 4'b1000);

        // Subtraction both ways
        issue(3'd0, 3'd0, 3'd0, 8'h05, 1'b1, 3'd1, 1'b1, 1'b0);
        issue(3'd0, 3'd0, 3'd0, 8'h03, 1'b1, 3'd2, 1'b1, 1'b0);
        issue(3'd1, 3'd1, 3'd2, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1);
        wait_drain();
        check("sub_pos_flags", flags_q, 4'b0110);
        issue(3'd1, 3'd2, 3'd1, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1);
        wait_drain();
        check("sub_neg_flags", flags_q, 4'b0000);

        // XOR to zero, then NOT without touching flags
        issue(3'd0, 3'd0, 3'd0, 8'h5A, 1'b1, 3'd1, 1'b1, 1'b0);
        issue(3'd5, 3'd1, 3'd1, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1);
        issue(3'd7, 3'd1, 3'd0, 8'h00, 1'b0, 3'd5, 1'b1, 1'b0);
        wait_drain();
        check("not_keeps_z", flags_q[0], 1);

        // Backpressure
        rdy_fixed = 1'b0;
        set_op(3'd0, 3'd0, 3'd0, 8'h01, 1'b1, 3'd5, 1'b1, 1'b0);
        @(negedge clk); check("bp_acc1", in_ready, 1); if (in_ready) model_exec();
        @(posedge clk); #1;
        set_op(3'd0, 3'd5, 3'd0, 8'h01, 1'b1, 3'd5, 1'b1, 1'b0);
        @(negedge clk); check("bp_acc2", in_ready, 1); if (in_ready) model_exec();
        @(posedge clk); #1;
        set_op(3'd0, 3'd5, 3'd0, 8'h01, 1'b1, 3'd6, 1'b1, 1'b0);
        @(negedge clk); check("bp_stall", in_ready, 0);
        held = {out_result, out_dest, out_flags};
        @(negedge clk); check("bp_stall2", in_ready, 0);
        check("bp_stable", {out_result, out_dest, out_flags}, held);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rdy_fixed = 1'b1;
        @(negedge clk); check("bp_acc3", in_ready, 1); if (in_ready) model_exec();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check("bp_drain2", out_valid, 1);
        @(negedge clk); check("bp_drain3", out_valid, 1);
        @(posedge clk); #1;
        wait_drain();

        // Flush an op sitting in EX
        saved_regs = m_regs;
        saved_flags = m_flags;
        issue(3'd0, 3'd0, 3'd0, 8'h11, 1'b1, 3'd4, 1'b1, 1'b1);
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        m_regs = saved_regs;
        m_flags = saved_flags;
        void'(exp_q.pop_back());
        @(negedge clk); check("flush_out_valid", out_valid, 0);
        check("flush_flags", flags_q, saved_flags);
        @(negedge clk); check("flush_out_valid2", out_valid, 0);
        @(posedge clk); #1;
        issue(3'd0, 3'd4, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
        wait_drain();

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain();
        read_all_regs();

        // Asynchronous reset with EX and WB both occupied
        rdy_fixed = 1'b0;
        issue(3'd0, 3'd0, 3'd0, 8'h05, 1'b1, 3'd7, 1'b1, 1'b1);
        issue(3'd0, 3'd7, 3'd0, 8'h01, 1'b1, 3'd7, 1'b1, 1'b1);
        check("pre_rst_flags", flags_q, 4'b0010);
        check("pre_rst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_flags_q", flags_q, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk); #1;
        read_all_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
